fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter H_RES, default 320: framebuffer width in pixels.
REQ-002 Parameter V_RES, default 240: framebuffer height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of 2): camera write FIFO entries.
REQ-004 The port list SHALL be:
  - pclk  in  1  pixel clock; the only clock, all logic on its rising edge.
  - rst  in  1  synchronous, active-high reset.
  - cam_we  in  1  camera pixel write request.
  - cam_addr  in  17  camera pixel address (y*H_RES+x).
  - cam_data  in  12  camera pixel RGB444.
  - cam_ready  out  1  FIFO can accept a push.
  - vga_x  in  10  current VGA column (0..639).
  - vga_y  in  10  current VGA row (0..479).
  - video_on  in  1  VGA active-area flag.
  - ram_addr  out  17  BRAM address.
  - ram_we  out  1  BRAM write enable.
  - ram_wdata  out  12  BRAM write data.
  - ram_rdata  in  12  BRAM read data, valid 1 cycle after address.
  - pix_out  out  12  RGB444 pixel to DAC.
  - overflow  out  1  sticky flag: a camera write was dropped.
  - test_en  in  1  test-pattern select (present only with FB_TEST_PATTERN_EN).

Function
REQ-005 The block SHALL share one single-port BRAM between camera writes and VGA reads, one access per cycle.
REQ-006 A read request SHALL exist in any cycle with video_on=1 and vga_x[0]=0 (2x horizontal upscale).
REQ-007 Read address SHALL be (vga_y>>1)*H_RES + (vga_x>>1), computed in 17 bits.
REQ-008 Read requests SHALL have absolute priority; a FIFO entry SHALL be written only in cycles with no read request.
REQ-009 FSM states: IDLE (no access), RD (ram_we=0, read addr driven), WR (ram_we=1, FIFO head driven, FIFO popped); next state chosen each cycle: RD if read request, else WR if FIFO non-empty, else IDLE.
REQ-010 ram_addr, ram_we, ram_wdata SHALL be registered outputs of the FSM (1-cycle latency from request).
REQ-011 pix_out SHALL be registered; pixel for input (vga_x,vga_y) SHALL appear exactly 2 cycles later, held for 2 cycles (even and odd column).
REQ-012 pix_out SHALL be 12'h000 whenever video_on delayed by 2 cycles is 0.
REQ-013 cam_ready SHALL equal NOT full (registered FIFO count).
REQ-014 Push with cam_ready=0 SHALL be dropped, FIFO unchanged, and overflow set to 1 next cycle, held until reset.
REQ-015 Push and pop in the same cycle SHALL leave count unchanged; push when full is dropped even if a pop occurs that cycle.
REQ-016 No bypass: a push into an empty FIFO SHALL be written to BRAM no earlier than 2 cycles later.
REQ-017 FIFO order SHALL be preserved; pointers wrap modulo FIFO_DEPTH.
REQ-018 cam_addr >= H_RES*V_RES SHALL be accepted into the FIFO but discarded at pop with ram_we=0.

Reset
REQ-019 On rst=1 at a pclk edge: FSM to IDLE, FIFO emptied, ram_we=0, ram_addr=0, ram_wdata=0, pix_out=0, overflow=0, cam_ready=1.
REQ-020 rst mid-write SHALL abort any pending FIFO entries; no ram_we pulse in the cycle after rst.

Configuration
REQ-021 Macro FB_TEST_PATTERN_EN: when defined, test_en port exists and test_en=1 replaces pix_out active data with 8 vertical colour bars (bar = vga_x[9:7]) at the same 2-cycle latency, arbitration unchanged; when undefined, test_en port and pattern logic are absent.

Verification
REQ-022 Reset: rst=1 for 3 cycles with cam_we=1 -> all outputs at reset values, overflow=0, no ram_we.
REQ-023 Active line, FIFO empty, ram_rdata=addr[11:0] model -> ram_addr sequence 0,0(hold),1,... at even x; pix_out pairs match with 2-cycle latency.
REQ-024 Burst of 6 pushes during active video, FIFO_DEPTH=4 -> pushes 1-4 accepted, cam_ready low, later drop sets overflow=1; writes land only on odd-x cycles in FIFO order.
REQ-025 Push at vga_x=638 then blanking -> write completes within 2 cycles; push with cam_addr=76800 -> no ram_we.
REQ-026 Simultaneous push/pop at count 2 -> count stays 2; push while full with pop -> dropped, overflow=1.
REQ-027 With FB_TEST_PATTERN_EN, test_en=1 at vga_x=130 -> pix_out equals bar-1 colour 2 cycles later; video_on=0 -> 12'h000.

Source files
------------

// File: rtl/fb_arbiter.sv
// Framebuffer BRAM arbiter: VGA reads (2x upscaled) take priority over a small camera write FIFO.
// Optional macro FB_TEST_PATTERN_EN adds the test_en port and an 8-bar colour pattern on pix_out.
module fb_arbiter #(
   parameter int H_RES      = 320,
   parameter int V_RES      = 240,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        cam_we,
   input  logic [16:0] cam_addr,
   input  logic [11:0] cam_data,
   output logic        cam_ready,
   input  logic [9:0]  vga_x,
   input  logic [9:0]  vga_y,
   input  logic        video_on,
   output logic [16:0] ram_addr,
   output logic        ram_we,
   output logic [11:0] ram_wdata,
   input  logic [11:0] ram_rdata,
   output logic [11:0] pix_out,
   output logic        overflow
`ifdef FB_TEST_PATTERN_EN
   ,
   input  logic        test_en
`endif
);

   localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [16:0]     H_RES_W  = 17'(H_RES);
   localparam logic [16:0]     FB_SIZE  = 17'(H_RES * V_RES);

   typedef struct packed {
      logic [16:0] addr;
      logic [11:0] data;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR
   } state_t;

   entry_t        r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   state_t        r_state;
   state_t        w_next_state;
   logic          r_ram_we;
   logic [16:0]   r_ram_addr;
   logic [11:0]   r_ram_wdata;
   logic          w_ram_we_d;
   logic [16:0]   w_ram_addr_d;
   logic [11:0]   w_ram_wdata_d;

   logic          r_von_d1;
   logic [11:0]   r_pix;

   logic          w_rd_req;
   logic [16:0]   w_rd_addr;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   entry_t        w_head;

   // Even columns only: each BRAM pixel covers two screen columns and two rows.
   assign w_rd_req  = video_on & ~vga_x[0];
   assign w_rd_addr = 17'(vga_y >> 1) * H_RES_W + 17'(vga_x >> 1);

   assign cam_ready = (r_count != FULL_CNT);
   assign w_push    = cam_we & cam_ready;
   assign w_drop    = cam_we & ~cam_ready;
   assign w_pop     = (w_next_state == S_WR);
   assign w_head    = r_mem[r_rd_ptr];

   // NOTE: storage array has no reset; the pointers and count alone define validity.
   always_ff @(posedge pclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{addr: cam_addr, data: cam_data};
      end
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count    <= r_count + CW'(w_push) - CW'(w_pop);
         r_overflow <= r_overflow | w_drop;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
      end else begin
         r_state     <= w_next_state;
         r_ram_we    <= w_ram_we_d;
         r_ram_addr  <= w_ram_addr_d;
         r_ram_wdata <= w_ram_wdata_d;
      end
   end

   always_comb begin
      w_next_state = S_IDLE;
      if (w_rd_req) begin
         w_next_state = S_RD;
      end else if (r_count != '0) begin
         w_next_state = S_WR;
      end
   end

   // NOTE: defaults first so every path assigns every output (no latches).
   always_comb begin
      w_ram_we_d    = 1'b0;
      w_ram_addr_d  = r_ram_addr;
      w_ram_wdata_d = r_ram_wdata;
      case (w_next_state)
         S_RD: w_ram_addr_d = w_rd_addr;
         S_WR: begin
            // Out-of-range entries are popped silently; the bus is left untouched.
            if (w_head.addr < FB_SIZE) begin
               w_ram_we_d    = 1'b1;
               w_ram_addr_d  = w_head.addr;
               w_ram_wdata_d = w_head.data;
            end
         end
         default: ;
      endcase
   end

`ifdef FB_TEST_PATTERN_EN
   logic       r_test_d1;
   logic [2:0] r_bar_d1;

   function automatic logic [11:0] bar_colour(input logic [2:0] bar);
      case (bar)
         3'd0:    bar_colour = 12'hFFF;
         3'd1:    bar_colour = 12'hFF0;
         3'd2:    bar_colour = 12'h0FF;
         3'd3:    bar_colour = 12'h0F0;
         3'd4:    bar_colour = 12'hF0F;
         3'd5:    bar_colour = 12'hF00;
         3'd6:    bar_colour = 12'h00F;
         default: bar_colour = 12'h000;
      endcase
   endfunction

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_test_d1 <= 1'b0;
         r_bar_d1  <= '0;
      end else begin
         r_test_d1 <= test_en;
         r_bar_d1  <= vga_x[9:7];
      end
   end
`endif

   // BRAM data is captured only in the read cycle, so it holds across the odd column.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_von_d1 <= 1'b0;
         r_pix    <= '0;
      end else begin
         r_von_d1 <= video_on;
         if (!r_von_d1) begin
            r_pix <= '0;
`ifdef FB_TEST_PATTERN_EN
         end else if (r_test_d1) begin
            r_pix <= bar_colour(r_bar_d1);
`endif
         end else if (r_state == S_RD) begin
            r_pix <= ram_rdata;
         end
      end
   end

   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign pix_out   = r_pix;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter; the BRAM model returns ram_addr[11:0] for the presented address.
module tb_fb_arbiter;

   logic        pclk = 1'b0;
   logic        rst;
   logic        cam_we;
   logic [16:0] cam_addr;
   logic [11:0] cam_data;
   logic        cam_ready;
   logic [9:0]  vga_x;
   logic [9:0]  vga_y;
   logic        video_on;
   logic [16:0] ram_addr;
   logic        ram_we;
   logic [11:0] ram_wdata;
   logic [11:0] ram_rdata;
   logic [11:0] pix_out;
   logic        overflow;
`ifdef FB_TEST_PATTERN_EN
   logic        test_en = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 pclk = ~pclk;

   assign ram_rdata = ram_addr[11:0];

   fb_arbiter dut (
      .pclk      (pclk),
      .rst       (rst),
      .cam_we    (cam_we),
      .cam_addr  (cam_addr),
      .cam_data  (cam_data),
      .cam_ready (cam_ready),
      .vga_x     (vga_x),
      .vga_y     (vga_y),
      .video_on  (video_on),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .pix_out   (pix_out),
      .overflow  (overflow)
`ifdef FB_TEST_PATTERN_EN
      ,
      .test_en   (test_en)
`endif
   );

   typedef struct {
      logic        cw;
      logic [16:0] ca;
      logic [11:0] cd;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        von;
      logic        e_we;
      logic [16:0] e_addr;
      logic [11:0] e_wdata;
      logic        e_rdy;
      logic [11:0] e_pix;
      logic        e_ovf;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs [NV];

   function automatic vec_t v(input logic cw, input int ca, input int cd, input int x, input int y,
                              input logic von, input logic we, input int a, input int wd,
                              input logic rdy, input int pix, input logic ovf);
      vec_t r;
      r.cw = cw;  r.ca = 17'(ca);  r.cd = 12'(cd);
      r.x = 10'(x);  r.y = 10'(y);  r.von = von;
      r.e_we = we;  r.e_addr = 17'(a);  r.e_wdata = 12'(wd);
      r.e_rdy = rdy;  r.e_pix = 12'(pix);  r.e_ovf = ovf;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // columns: cam_we, cam_addr, cam_data, x, y, video_on | ram_we, ram_addr, ram_wdata, cam_ready, pix_out, overflow
      vecs[0]  = v(0, 0,     0,      0,   2,   1, 0, 320,   'h000, 1, 'h000, 0);
      vecs[1]  = v(0, 0,     0,      1,   2,   1, 0, 320,   'h000, 1, 'h140, 0);
      vecs[2]  = v(0, 0,     0,      2,   2,   1, 0, 321,   'h000, 1, 'h140, 0);
      vecs[3]  = v(0, 0,     0,      3,   2,   1, 0, 321,   'h000, 1, 'h141, 0);
      vecs[4]  = v(0, 0,     0,      4,   2,   1, 0, 322,   'h000, 1, 'h141, 0);
      vecs[5]  = v(0, 0,     0,      5,   2,   1, 0, 322,   'h000, 1, 'h142, 0);
      vecs[6]  = v(0, 0,     0,      6,   2,   0, 0, 322,   'h000, 1, 'h142, 0);
      vecs[7]  = v(0, 0,     0,      0,   0,   0, 0, 322,   'h000, 1, 'h000, 0);
      vecs[8]  = v(1, 1000,  'hA01,  0,   4,   1, 0, 640,   'h000, 1, 'h000, 0);
      vecs[9]  = v(1, 1001,  'hA02,  1,   4,   1, 1, 1000,  'hA01, 1, 'h280, 0);
      vecs[10] = v(1, 1002,  'hA03,  2,   4,   1, 0, 641,   'hA01, 1, 'h280, 0);
      vecs[11] = v(1, 1003,  'hA04,  3,   4,   1, 1, 1001,  'hA02, 1, 'h281, 0);
      vecs[12] = v(1, 1004,  'hA05,  4,   4,   1, 0, 642,   'hA02, 1, 'h281, 0);
      vecs[13] = v(1, 1005,  'hA06,  5,   4,   1, 1, 1002,  'hA03, 1, 'h282, 0);
      vecs[14] = v(1, 1006,  'hA07,  6,   4,   1, 0, 643,   'hA03, 0, 'h282, 0);
      vecs[15] = v(1, 1007,  'hA08,  7,   4,   1, 1, 1003,  'hA04, 1, 'h283, 1);
      vecs[16] = v(0, 0,     0,      8,   4,   1, 0, 644,   'hA04, 1, 'h283, 1);
      vecs[17] = v(0, 0,     0,      0,   0,   0, 1, 1004,  'hA05, 1, 'h284, 1);
      vecs[18] = v(0, 0,     0,      0,   0,   0, 1, 1005,  'hA06, 1, 'h000, 1);
      vecs[19] = v(0, 0,     0,      0,   0,   0, 1, 1006,  'hA07, 1, 'h000, 1);
      vecs[20] = v(0, 0,     0,      0,   0,   0, 0, 1006,  'hA07, 1, 'h000, 1);
      vecs[21] = v(1, 2000,  'hB01,  638, 479, 1, 0, 76799, 'hA07, 1, 'h000, 1);
      vecs[22] = v(0, 0,     0,      639, 479, 1, 1, 2000,  'hB01, 1, 'hBFF, 1);
      vecs[23] = v(1, 76800, 'hC01,  0,   0,   0, 0, 2000,  'hB01, 1, 'hBFF, 1);
      vecs[24] = v(0, 0,     0,      0,   0,   0, 0, 2000,  'hB01, 1, 'h000, 1);
      vecs[25] = v(0, 0,     0,      0,   0,   0, 0, 2000,  'hB01, 1, 'h000, 1);

      // Reset held three cycles with a pending camera write.
      rst = 1'b1;  cam_we = 1'b1;  cam_addr = 17'd5;  cam_data = 12'h123;
      vga_x = '0;  vga_y = '0;  video_on = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rst%0d_ram_we", i), 32'(ram_we), 32'd0);
      end
      check("rst_ram_addr",  32'(ram_addr),  32'd0);
      check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      check("rst_pix_out",   32'(pix_out),   32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      check("rst_cam_ready", 32'(cam_ready), 32'd1);

      rst = 1'b0;  cam_we = 1'b0;
      step();
      check("rel_ram_we", 32'(ram_we), 32'd0);

      // Active line, burst into a full FIFO, late push, out-of-range push.
      for (int i = 0; i < NV; i++) begin
         cam_we = vecs[i].cw;  cam_addr = vecs[i].ca;  cam_data = vecs[i].cd;
         vga_x = vecs[i].x;  vga_y = vecs[i].y;  video_on = vecs[i].von;
         step();
         check($sformatf("v%0d_ram_we", i),    32'(ram_we),    32'(vecs[i].e_we));
         check($sformatf("v%0d_ram_addr", i),  32'(ram_addr),  32'(vecs[i].e_addr));
         check($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_wdata));
         check($sformatf("v%0d_cam_ready", i), 32'(cam_ready), 32'(vecs[i].e_rdy));
         check($sformatf("v%0d_pix_out", i),   32'(pix_out),   32'(vecs[i].e_pix));
         check($sformatf("v%0d_overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
      end

      // Reset while entries are queued: queue discarded, overflow cleared.
      video_on = 1'b0;  vga_x = '0;  vga_y = '0;
      cam_we = 1'b1;  cam_addr = 17'd3000;  cam_data = 12'hD01;
      step();
      check("mr_a_ram_we", 32'(ram_we), 32'd0);
      cam_addr = 17'd3001;  cam_data = 12'hD02;
      step();
      check("mr_b_ram_we",   32'(ram_we),   32'd1);
      check("mr_b_ram_addr", 32'(ram_addr), 32'd3000);
      rst = 1'b1;  cam_addr = 17'd3002;  cam_data = 12'hD03;
      step();
      check("mr_c_ram_we",    32'(ram_we),    32'd0);
      check("mr_c_ram_addr",  32'(ram_addr),  32'd0);
      check("mr_c_ram_wdata", 32'(ram_wdata), 32'd0);
      check("mr_c_overflow",  32'(overflow),  32'd0);
      check("mr_c_cam_ready", 32'(cam_ready), 32'd1);
      rst = 1'b0;  cam_we = 1'b0;
      step();
      check("mr_d_ram_we", 32'(ram_we), 32'd0);
      step();
      check("mr_e_ram_we", 32'(ram_we), 32'd0);

`ifdef FB_TEST_PATTERN_EN
      // Column 130 lies in bar 1 (yellow).
      test_en = 1'b1;  video_on = 1'b1;  vga_y = 10'd0;  vga_x = 10'd130;
      step();
      vga_x = 10'd131;
      step();
      check("tp_bar1_even", 32'(pix_out), 32'h0FF0);
      vga_x = 10'd132;
      step();
      check("tp_bar1_odd", 32'(pix_out), 32'h0FF0);
      video_on = 1'b0;
      step();
      step();
      check("tp_blank", 32'(pix_out), 32'h0000);
      test_en = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
